// File: rtl/toy_lsu_id_alloc.sv
// In-order LSU-ID allocator with group flow control, wrap-bit pointers and cancel rewind.
// Optional TOY_LSU_ALLOC_STAT_EN adds a saturating dispatch-stall counter output stall_cnt.
module toy_lsu_id_alloc #(
   parameter int unsigned S_CHANNEL = 4,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned FLUSH_CYC = 2
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [S_CHANNEL-1:0]                     v_disp_vld,
   input  logic [S_CHANNEL-1:0]                     v_disp_is_mem,
   output logic                                     disp_rdy,
   output logic [S_CHANNEL-1:0][$clog2(DEPTH):0]    v_disp_lsu_id,
   input  logic [$clog2(DEPTH):0]                   lsu_buffer_rd_ptr,
   input  logic                                     cancel_en,
   output logic [$clog2(DEPTH):0]                   alloc_ptr,
   output logic [$clog2(DEPTH):0]                   free_cnt,
   output logic                                     alloc_err
`ifdef TOY_LSU_ALLOC_STAT_EN
   ,
   output logic [31:0]                              stall_cnt
`endif
);

   localparam int unsigned DW = $clog2(DEPTH);
   localparam int unsigned PW = DW + 1;
   localparam int unsigned CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t               state;
   logic [CW-1:0]        flush_cnt;
   logic [PW-1:0]        occ;
   logic [PW-1:0]        need;
   logic [S_CHANNEL-1:0] mem_vld;
   logic                 any_vld;
   logic                 fire;

   assign mem_vld  = v_disp_vld & v_disp_is_mem;
   assign any_vld  = |v_disp_vld;
   assign occ      = alloc_ptr - lsu_buffer_rd_ptr;
   assign free_cnt = (occ > PW'(DEPTH)) ? '0 : PW'(DEPTH) - occ;
   assign disp_rdy = (state == RUN) && !cancel_en && (free_cnt >= PW'(S_CHANNEL));
   assign fire     = any_vld && disp_rdy;

   // Each channel's ID is alloc_ptr plus the count of memory ops on lower channels.
   always_comb begin
      need = '0;
      for (int unsigned i = 0; i < S_CHANNEL; i++) begin
         v_disp_lsu_id[i] = alloc_ptr + need;
         need             = need + PW'(mem_vld[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alloc_ptr <= '0;
         state     <= RUN;
         flush_cnt <= '0;
         alloc_err <= 1'b0;
      end else begin
         if (occ > PW'(DEPTH)) begin
            alloc_err <= 1'b1;
         end
         // Cancel wins over any same-cycle fire and restarts the flush window.
         if (cancel_en) begin
            alloc_ptr <= '0;
            state     <= FLUSH;
            flush_cnt <= CW'(FLUSH_CYC - 1);
         end else begin
            if (fire) begin
               alloc_ptr <= alloc_ptr + need;
            end
            if (state == FLUSH) begin
               if (flush_cnt == '0) begin
                  state <= RUN;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
         end
      end
   end

`ifdef TOY_LSU_ALLOC_STAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (any_vld && !disp_rdy && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_toy_lsu_id_alloc.sv
// Scoreboard bench for toy_lsu_id_alloc: a cycle model pushes expectations, a negedge monitor checks.
// Build with TOY_LSU_ALLOC_STAT_EN defined to also check stall_cnt.
module tb_toy_lsu_id_alloc;

   localparam int S     = 4;
   localparam int DEPTH = 16;
   localparam int FC    = 2;
   localparam int PW    = $clog2(DEPTH) + 1;
   localparam int M     = 2 * DEPTH;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [S-1:0]               v_disp_vld;
   logic [S-1:0]               v_disp_is_mem;
   logic                       disp_rdy;
   logic [S-1:0][PW-1:0]       v_disp_lsu_id;
   logic [PW-1:0]              lsu_buffer_rd_ptr;
   logic                       cancel_en;
   logic [PW-1:0]              alloc_ptr;
   logic [PW-1:0]              free_cnt;
   logic                       alloc_err;
`ifdef TOY_LSU_ALLOC_STAT_EN
   logic [31:0]                stall_cnt;
`endif

   toy_lsu_id_alloc #(.S_CHANNEL(S), .DEPTH(DEPTH), .FLUSH_CYC(FC)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .v_disp_vld(v_disp_vld),
      .v_disp_is_mem(v_disp_is_mem),
      .disp_rdy(disp_rdy),
      .v_disp_lsu_id(v_disp_lsu_id),
      .lsu_buffer_rd_ptr(lsu_buffer_rd_ptr),
      .cancel_en(cancel_en),
      .alloc_ptr(alloc_ptr),
      .free_cnt(free_cnt),
      .alloc_err(alloc_err)
`ifdef TOY_LSU_ALLOC_STAT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rdy;
      int            ids[S];
      int            free;
      int            alloc;
      logic          err;
      longint        stall;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference state: plain integers, pointers kept modulo 2*DEPTH.
   int     m_alloc, m_rd, m_block;
   logic   m_err;
   longint m_stall;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int occ_of(input int a, input int r);
      return ((a - r) % M + M) % M;
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("disp_rdy", int'(disp_rdy), int'(e.rdy));
         for (int i = 0; i < S; i++) chk($sformatf("lsu_id[%0d]", i), int'(v_disp_lsu_id[i]), e.ids[i]);
         chk("free_cnt", int'(free_cnt), e.free);
         chk("alloc_ptr", int'(alloc_ptr), e.alloc);
         chk("alloc_err", int'(alloc_err), int'(e.err));
`ifdef TOY_LSU_ALLOC_STAT_EN
         chk("stall_cnt", int'(stall_cnt), int'(e.stall));
`endif
      end
   end

   task automatic model_reset();
      m_alloc = 0; m_rd = 0; m_block = 0; m_err = 1'b0; m_stall = 0;
   endtask

   // Drive one cycle of stimulus, push the expected view of that cycle, then advance the model.
   task automatic step(input logic [S-1:0] v, input logic [S-1:0] mm, input int rd, input logic c);
      exp_t e;
      int occ, k;
      v_disp_vld = v; v_disp_is_mem = mm; lsu_buffer_rd_ptr = PW'(rd); cancel_en = c;
      m_rd = rd % M;
      occ = occ_of(m_alloc, m_rd);
      e.free = (occ > DEPTH) ? 0 : DEPTH - occ;
      e.rdy = (m_block == 0) && !c && (e.free >= S);
      k = 0;
      for (int i = 0; i < S; i++) begin
         e.ids[i] = (m_alloc + k) % M;
         if (v[i] && mm[i]) k++;
      end
      e.alloc = m_alloc; e.err = m_err; e.stall = m_stall;
      q.push_back(e);
      @(posedge clk);
      if (rst_n) begin
         if (occ > DEPTH) m_err = 1'b1;
         if (c) begin
            m_alloc = 0; m_block = FC;
         end else begin
            if ((v != 0) && e.rdy) m_alloc = (m_alloc + k) % M;
            if (m_block > 0) m_block--;
         end
         if ((v != 0) && !e.rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      step('0, '0, 0, 1'b0);
      step('0, '0, 0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_n;
      logic pc, c;
      rst_n = 1'b0; v_disp_vld = '0; v_disp_is_mem = '0; lsu_buffer_rd_ptr = '0; cancel_en = 1'b0;
      model_reset();
      @(posedge clk); #1;
      do_reset();

      // Mixed group, then fill to occ=13 and release by one read.
      step(4'b1111, 4'b1011, 0, 1'b0);
      step(4'b1111, 4'b1111, 0, 1'b0);
      step(4'b1111, 4'b1111, 0, 1'b0);
      step(4'b1111, 4'b0011, 0, 1'b0);
      step(4'b1111, 4'b1111, 0, 1'b0);
      step(4'b1111, 4'b1111, 0, 1'b0);
      step(4'b1111, 4'b1111, 1, 1'b0);
      step(4'b0000, 4'b0000, 1, 1'b0);

      // Walk alloc_ptr to 14, fire across the index wrap, then reach full with differing wrap bits.
      do_reset();
      step(4'b1111, 4'b1111, 0, 1'b0);
      step(4'b1111, 4'b1111, 4, 1'b0);
      step(4'b1111, 4'b1111, 8, 1'b0);
      step(4'b0011, 4'b0011, 12, 1'b0);
      step(4'b1111, 4'b1111, 14, 1'b0);
      step(4'b1111, 4'b1111, 2, 1'b0);
      step(4'b1111, 4'b1111, 2, 1'b0);

      // Cancel at alloc_ptr=7 with a full group, then a second cancel inside the flush window.
      do_reset();
      step(4'b1111, 4'b1110, 0, 1'b0);
      step(4'b1111, 4'b1111, 0, 1'b0);
      step(4'b1111, 4'b1111, 0, 1'b1);
      for (int i = 0; i < 3; i++) step(4'b1111, 4'b0001, 0, 1'b0);
      step(4'b1111, 4'b1111, 0, 1'b1);
      step(4'b1111, 4'b1111, 0, 1'b0);
      step(4'b1111, 4'b1111, 0, 1'b1);
      for (int i = 0; i < 4; i++) step(4'b0001, 4'b0001, 0, 1'b0);

      // Reset in the middle of a flush window.
      step(4'b0001, 4'b0001, 0, 1'b1);
      do_reset();
      step(4'b0001, 4'b0001, 0, 1'b0);

      // Overflow: rd_ptr one ahead of alloc_ptr makes the flag sticky until reset.
      step(4'b0000, 4'b0000, 2, 1'b0);
      step(4'b0000, 4'b0000, 1, 1'b0);
      step(4'b0000, 4'b0000, 1, 1'b0);
      do_reset();
      step(4'b0000, 4'b0000, 0, 1'b0);

      // Blocked dispatch counts stalls; a cancel does not clear the count.
      for (int i = 0; i < 4; i++) step(4'b1111, 4'b1111, 0, 1'b0);
      for (int i = 0; i < 5; i++) step(4'b0001, 4'b0001, 0, 1'b0);
      step(4'b0000, 4'b0000, 0, 1'b1);
      step(4'b0000, 4'b0000, 0, 1'b0);

      // Random traffic with a buffer that drains up to its occupancy and zeroes rd_ptr on cancel.
      do_reset();
      pc = 1'b0;
      for (int n = 0; n < 600; n++) begin
         c = ($urandom_range(0, 24) == 0);
         if (pc) rd_n = 0;
         else    rd_n = (m_rd + $urandom_range(0, occ_of(m_alloc, m_rd))) % M;
         step(S'($urandom), S'($urandom), rd_n, c);
         pc = c;
      end

      step('0, '0, m_rd, 1'b0);
      @(negedge clk); #1;
      chk("scoreboard_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
